// File: rtl/gate_timing_ctrl.sv
// Measurement sequencer for the frequency-meter decade chain: generates the count
// gate, store strobe and chain clear, and auto-ranges the gate time (1 s / 0.1 s / 0.01 s).
module gate_timing_ctrl #(
    parameter int unsigned TICK_DIV = 10000,
    parameter int unsigned DIV_W    = 14
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       start,
    input  logic       auto_range,
    input  logic [1:0] manual_range,
    input  logic       ovf_in,
    input  logic       msd_zero,
    output logic       gate_en,
    output logic       store,
    output logic       clear_n,
    output logic [1:0] range,
    output logic       ovf_flag,
    output logic       busy
);

    localparam int unsigned TICK_W = 7;
    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_GATE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_STORE  = 3'd4,
        ST_EVAL   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    presc_q, presc_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [TICK_W-1:0]   tick_last_c;
    logic                settle_q, settle_d;
    logic                ovf_seen_q, ovf_seen_d;
    logic [1:0]          range_q, range_d;
    logic                ovf_flag_q, ovf_flag_d;
    logic                gate_done_c;
    logic                gate_en_d, store_d, clear_n_d, busy_d;

    // Last tick index of the gate for the active range (100 / 10 / 1 ticks).
    always_comb begin
        case (range_q)
            2'd0:    tick_last_c = TICK_W'(99);
            2'd1:    tick_last_c = TICK_W'(9);
            default: tick_last_c = TICK_W'(0);
        endcase
    end

    assign gate_done_c = (presc_q == PRESC_LAST) && (tick_q == tick_last_c);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_CLR;
            ST_CLR:    state_d = ST_GATE;
            ST_GATE:   if (gate_done_c) state_d = ST_SETTLE;
            ST_SETTLE: if (settle_q) state_d = ST_STORE;
            ST_STORE:  state_d = ST_EVAL;
            ST_EVAL:   state_d = start ? ST_CLR : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        gate_en_d = (state_d == ST_GATE);
        store_d   = (state_d == ST_STORE);
        clear_n_d = (state_d != ST_CLR);
        busy_d    = (state_d != ST_IDLE);
    end

    // Prescaler, tick count, overflow capture and range decision.
    always_comb begin
        presc_d    = presc_q;
        tick_d     = tick_q;
        settle_d   = settle_q;
        ovf_seen_d = ovf_seen_q;
        range_d    = range_q;
        ovf_flag_d = ovf_flag_q;
        case (state_q)
            ST_CLR: begin
                presc_d    = '0;
                tick_d     = '0;
                settle_d   = 1'b0;
                ovf_seen_d = 1'b0;
                if (!auto_range) begin
                    range_d = (manual_range == 2'd3) ? 2'd2 : manual_range;
                end
            end
            ST_GATE: begin
                if (ovf_in) ovf_seen_d = 1'b1;
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (!gate_done_c) tick_d = tick_q + TICK_W'(1);
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            ST_SETTLE: begin
                if (ovf_in) ovf_seen_d = 1'b1;
                settle_d = 1'b1;
            end
            ST_EVAL: begin
                ovf_flag_d = ovf_seen_q && (range_q == 2'd2);
                if (auto_range) begin
                    if (ovf_seen_q && (range_q < 2'd2)) begin
                        range_d = range_q + 2'd1;
                    end else if (!ovf_seen_q && msd_zero && (range_q > 2'd0)) begin
                        range_d = range_q - 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            presc_q    <= '0;
            tick_q     <= '0;
            settle_q   <= 1'b0;
            ovf_seen_q <= 1'b0;
            range_q    <= 2'd0;
            ovf_flag_q <= 1'b0;
            gate_en    <= 1'b0;
            store      <= 1'b0;
            clear_n    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            settle_q   <= settle_d;
            ovf_seen_q <= ovf_seen_d;
            range_q    <= range_d;
            ovf_flag_q <= ovf_flag_d;
            gate_en    <= gate_en_d;
            store      <= store_d;
            clear_n    <= clear_n_d;
            busy       <= busy_d;
        end
    end

    assign range    = range_q;
    assign ovf_flag = ovf_flag_q;

endmodule

// File: tb/tb_gate_timing_ctrl.sv
// Testbench for gate_timing_ctrl: measurement-level vector table, hand sequences for
// start/reset corners, and random stimulus checked cycle by cycle against a timeline model.
module tb_gate_timing_ctrl;

    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned DIV_W    = 2;

    logic       clk = 1'b0;
    logic       nRST;
    logic       start;
    logic       auto_range;
    logic [1:0] manual_range;
    logic       ovf_in;
    logic       msd_zero;
    logic       gate_en;
    logic       store;
    logic       clear_n;
    logic [1:0] range;
    logic       ovf_flag;
    logic       busy;

    gate_timing_ctrl #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) dut (
        .clk(clk), .nRST(nRST), .start(start), .auto_range(auto_range),
        .manual_range(manual_range), .ovf_in(ovf_in), .msd_zero(msd_zero),
        .gate_en(gate_en), .store(store), .clear_n(clear_n), .range(range),
        .ovf_flag(ovf_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model: a measurement is offset 0 = clear, 1..G = gate,
    // G+1..G+2 = settle, G+3 = store, G+4 = evaluate.
    bit m_active;
    int m_off;
    int m_G;
    int m_range;
    bit m_flag;
    bit m_seen;

    function automatic int ticks_of(input int r);
        return (r == 0) ? 100 : ((r == 1) ? 10 : 1);
    endfunction

    task automatic model_reset();
        m_active = 0; m_off = 0; m_G = 0; m_range = 0; m_flag = 0; m_seen = 0;
    endtask

    task automatic model_edge();
        if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_off    = 0;
            end
        end else if (m_off == 0) begin
            if (!auto_range) m_range = (manual_range == 2'd3) ? 2 : int'(manual_range);
            m_seen = 0;
            m_G    = ticks_of(m_range) * int'(TICK_DIV);
            m_off  = 1;
        end else if (m_off <= m_G + 3) begin
            if (m_off <= m_G + 2 && ovf_in) m_seen = 1;
            m_off++;
        end else begin
            m_flag = m_seen && (m_range == 2);
            if (auto_range) begin
                if (m_seen) begin
                    if (m_range < 2) m_range++;
                end else if (msd_zero && m_range > 0) begin
                    m_range--;
                end
            end
            if (start) m_off = 0;
            else m_active = 0;
        end
    endtask

    function automatic int model_out();
        logic ge, st, cn;
        ge = m_active && m_off >= 1 && m_off <= m_G;
        st = m_active && m_off == m_G + 3;
        cn = !(m_active && m_off == 0);
        return int'({ge, st, cn, 2'(m_range), m_flag, m_active});
    endfunction

    function automatic int dut_out();
        return int'({gate_en, store, clear_n, range, ovf_flag, busy});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("cycle_outputs", dut_out(), model_out());
    endtask

    typedef struct {
        bit         auto_r;
        logic [1:0] man;
        bit         ovf;
        bit         msd;
        int         exp_gate;
        logic [1:0] exp_range;
        bit         exp_flag;
    } vec_t;

    vec_t tbl[14];

    task automatic run_vec(input int i);
        int  gcount;
        bit  saw;
        auto_range   = tbl[i].auto_r;
        manual_range = tbl[i].man;
        msd_zero     = tbl[i].msd;
        ovf_in       = 1'b0;
        gcount       = 0;
        saw          = 0;
        for (int c = 0; c < 1000 && !saw; c++) begin
            step();
            if (gate_en) begin
                gcount++;
                if (gcount == 1) manual_range = 2'($urandom);
                if (gcount == 2) ovf_in = tbl[i].ovf;
                if (gcount == 3) ovf_in = 1'b0;
            end
            if (store) saw = 1;
        end
        check($sformatf("store_seen_%0d", i), int'(saw), 1);
        check($sformatf("gate_len_%0d", i), gcount, tbl[i].exp_gate);
        step();
        step();
        check($sformatf("range_%0d", i), int'(range), int'(tbl[i].exp_range));
        check($sformatf("ovf_flag_%0d", i), int'(ovf_flag), int'(tbl[i].exp_flag));
    endtask

    initial begin
        int  gcount;
        int  bad;
        bit  saw;

        //        auto man   ovf msd gate range flag
        tbl[0]  = '{0, 2'd2, 0, 0,   4, 2'd2, 0};
        tbl[1]  = '{0, 2'd0, 0, 0, 400, 2'd0, 0};
        tbl[2]  = '{0, 2'd3, 0, 0,   4, 2'd2, 0};
        tbl[3]  = '{0, 2'd2, 1, 0,   4, 2'd2, 1};
        tbl[4]  = '{0, 2'd0, 0, 0, 400, 2'd0, 0};
        tbl[5]  = '{1, 2'd0, 1, 0, 400, 2'd1, 0};
        tbl[6]  = '{1, 2'd0, 1, 0,  40, 2'd2, 0};
        tbl[7]  = '{1, 2'd0, 1, 0,   4, 2'd2, 1};
        tbl[8]  = '{1, 2'd0, 0, 0,   4, 2'd2, 0};
        tbl[9]  = '{1, 2'd0, 0, 1,   4, 2'd1, 0};
        tbl[10] = '{1, 2'd0, 0, 1,  40, 2'd0, 0};
        tbl[11] = '{1, 2'd0, 0, 1, 400, 2'd0, 0};
        tbl[12] = '{1, 2'd0, 1, 1, 400, 2'd1, 0};
        tbl[13] = '{0, 2'd1, 0, 0,  40, 2'd1, 0};

        nRST = 1'b0; start = 1'b0; auto_range = 1'b0; manual_range = 2'd0;
        ovf_in = 1'b0; msd_zero = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_out(), int'(7'b0010000));
        nRST = 1'b1;
        step();
        step();

        // Continuous measurements driven from the vector table.
        auto_range = tbl[0].auto_r; manual_range = tbl[0].man;
        start = 1'b1;
        step();
        check("clear_1st_edge", int'(clear_n), 0);
        for (int i = 0; i < 14; i++) run_vec(i);

        // start dropped mid-gate: full gate, store, then idle.
        auto_range = 1'b0; manual_range = 2'd2; msd_zero = 1'b0;
        gcount = 0; saw = 0;
        for (int c = 0; c < 20 && !saw; c++) begin
            step();
            if (gate_en) begin
                gcount++;
                if (gcount == 2) start = 1'b0;
            end
            if (store) saw = 1;
        end
        check("stop_store_seen", int'(saw), 1);
        check("stop_gate_len", gcount, 4);
        step();
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (busy || !clear_n) bad++;
        end
        check("stop_idle_cycles", bad, 0);

        // Random stimulus against the model.
        start = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 99) < 2) start = ~start;
            if ($urandom_range(0, 19) == 0) begin
                auto_range   = 1'($urandom);
                manual_range = 2'($urandom);
            end
            ovf_in   = ($urandom_range(0, 49) == 0);
            msd_zero = 1'($urandom);
            step();
        end

        // Asynchronous reset in the middle of a gate.
        auto_range = 1'b0; manual_range = 2'd1; ovf_in = 1'b0; start = 1'b1;
        saw = 0;
        for (int c = 0; c < 2000 && !saw; c++) begin
            step();
            if (gate_en) saw = 1;
        end
        check("reset_seq_gate_reached", int'(saw), 1);
        step();
        step();
        #1 nRST = 1'b0;
        #1;
        model_reset();
        check("async_reset_outputs", dut_out(), int'(7'b0010000));
        #1 nRST = 1'b1;
        step();
        check("clear_after_release", int'(clear_n), 0);
        step();
        check("gate_2nd_edge", int'(gate_en), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_timing_ctrl.md
Name: gate_timing_ctrl

Overview:
Measurement sequencer for the frequency-meter decade counter chain. Generates the count gate (En), the store strobe and the chain clear from the system clock. Auto-ranges the gate time (1 s / 0.1 s / 0.01 s) from top-decade overflow and underflow indications. Sits between the system clock divider and the cascaded modulo-10 counters and latches.

Parameters:
TICK_DIV, 10000, system clock cycles per 10 ms base tick (1 MHz clk default)
DIV_W, 14, width of the tick prescaler; must hold TICK_DIV-1

Ports:
clk  input  1  system clock, all logic on rising edge
nRST  input  1  reset, asynchronous, active-low
start  input  1  level; 1 = run measurements continuously, 0 = stop after the current one
auto_range  input  1  1 = automatic ranging, 0 = use manual_range
manual_range  input  2  range code used when auto_range=0 (0, 1 or 2; 3 treated as 2)
ovf_in  input  1  carry out of the most-significant decade, synchronous to clk
msd_zero  input  1  1 = most-significant decade is 0 at end of gate
gate_en  output  1  count enable to the counter chain
store  output  1  one-cycle latch strobe to the display registers
clear_n  output  1  active-low synchronous clear to the counter chain
range  output  2  current range: 0 = 1 s gate, 1 = 0.1 s, 2 = 0.01 s; 3 is never driven
ovf_flag  output  1  overflow on the shortest range; updated at EVAL
busy  output  1  1 in every state except IDLE

Behaviour:
- Reset (nRST=0, takes effect at once, any state): state=IDLE, gate_en=0, store=0, clear_n=1, range=0, ovf_flag=0, prescaler=0, tick count=0, ovf_seen=0.
- All outputs are registered and change only on clk edges, except for the asynchronous reset.
- Gate ticks per range: range 0 = 100, range 1 = 10, range 2 = 1.
- Gate duration is exactly ticks*TICK_DIV clk cycles.
- States, with outputs:
  - IDLE: busy=0, gate_en=0, clear_n=1. If start=1, go to CLR on the next edge.
  - CLR: one cycle with clear_n=0. Prescaler and tick count reset. ovf_seen cleared. If auto_range=0, range loads manual_range here; 3 is mapped to 2. Then go to GATE.
  - GATE: gate_en=1. The prescaler counts 0..TICK_DIV-1 and wraps. The tick count increments on each wrap. When the last cycle of the last tick is reached, go to SETTLE. Any cycle with ovf_in=1 sets ovf_seen.
  - SETTLE: 2 cycles with gate_en=0, for chain ripple settle. ovf_in is still sampled during these cycles.
  - STORE: one cycle with store=1.
  - EVAL: one cycle. If auto_range=1:
    - ovf_seen and range<2: range+1.
    - else !ovf_seen and msd_zero and range>0: range-1.
    - else range is unchanged.
    - ovf_flag <= ovf_seen && (range==2), using the pre-update range. If auto_range=0, the ovf_flag rule is the same.
    - Then go to CLR if start=1, else IDLE.
- Latency: start rising in IDLE → clear_n=0 on the 1st edge after → gate_en=1 on the 2nd.
- Full cycle length: 1 + ticks*TICK_DIV + 2 + 1 + 1 clk cycles.
- start falling mid-measurement: the current sequence completes through EVAL, then goes to IDLE. No truncated gate and no missing store.
- manual_range or auto_range changes during GATE do not affect the current gate. They are sampled only at CLR and EVAL.
- Range saturates at 0 and 2. It never wraps and never outputs 3.
- ovf_in and msd_zero both asserted: overflow wins and range moves up.
- store and clear_n=0 are never active in the same cycle. gate_en is never 1 in the same cycle as either of them.

Test Plan:
- TICK_DIV=4, start=1, auto_range=0, manual_range=2, no ovf → clear_n low 1 cycle, gate_en high exactly 4 cycles, 2 idle cycles, store 1 cycle, then clear_n low again; period 9 cycles.
- Same settings with manual_range=0 → gate_en high exactly 400 cycles; manual_range=3 → 4 cycles (treated as 2).
- auto_range=1, range=0, pulse ovf_in once in each gate → range 0→1→2, then stays at 2 with ovf_flag=1 after the third EVAL. Drop ovf_in → ovf_flag=0 at the next EVAL.
- auto_range=1, range=2, no ovf, msd_zero=1 → range 2→1→0 on successive EVALs, then stays at 0. ovf_in=1 with msd_zero=1 → range goes up.
- Deassert start mid-GATE → gate runs to full length, store pulses, then IDLE with busy=0 and no further clear_n.
- Assert nRST=0 mid-GATE → gate_en=0 immediately (asynchronously), range=0, ovf_flag=0. Release with start=1 → CLR on the 1st edge after release.
